// File: rtl/counter_bank_arbiter.sv
// Bank of 64-bit event counters sharing one incrementer, granted round-robin from
// per-channel pending counts, with a 32-bit host read port and MSB-then-LSB snapshot.
`timescale 1ns/1ps
module counter_bank_arbiter #(
  parameter int N_CH   = 4,
  parameter int PEND_W = 4,
  parameter int CH_W   = 2
) (
  input  logic              i_clk,
  input  logic              i_areset,
  input  logic [N_CH-1:0]   i_event,
  input  logic              i_clear,
  input  logic              i_rd_req,
  input  logic [CH_W-1:0]   i_rd_ch,
  input  logic              i_rd_hi,
  output logic              o_rd_ack,
  output logic [31:0]       o_rd_data,
  output logic [N_CH-1:0]   o_drop,
  output logic              o_busy
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [CH_W-1:0]   LAST_RST = CH_W'(N_CH - 1);

  logic [63:0]       ctr_q  [N_CH];
  logic [PEND_W-1:0] pend_q [N_CH];
  logic [N_CH-1:0]   drop_q;
  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   gnt;
  logic [CH_W-1:0]   last_gnt_q;
  logic [CH_W-1:0]   gnt_ch;
  logic              gnt_vld;
  logic [31:0]       sample_lsb_q;
  logic [CH_W-1:0]   sample_ch_q;
  logic              sample_vld_q;
  logic              rd_ack_q;
  logic [31:0]       rd_data_q;
  logic [31:0]       rd_mux;
  logic              clr;

  assign clr = i_areset | i_clear;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      req[i] = (pend_q[i] != '0);
    end
  end

  // Round-robin search begins one past the last granted channel.
  always_comb begin
    logic [CH_W-1:0] cand;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    cand    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CH_W'((int'(last_gnt_q) + k) % N_CH);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_ch  = cand;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      gnt[i] = gnt_vld && (gnt_ch == CH_W'(i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (clr) begin
      for (int i = 0; i < N_CH; i++) begin
        pend_q[i] <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        case ({i_event[i], gnt[i]})
          2'b10: begin
            if (pend_q[i] == PEND_MAX) drop_q[i] <= 1'b1;
            else                       pend_q[i] <= pend_q[i] + PEND_W'(1);
          end
          2'b01:   pend_q[i] <= pend_q[i] - PEND_W'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (clr) begin
      for (int i = 0; i < N_CH; i++) begin
        ctr_q[i] <= '0;
      end
      last_gnt_q <= LAST_RST;
    end else if (gnt_vld) begin
      ctr_q[gnt_ch] <= ctr_q[gnt_ch] + 64'd1;
      last_gnt_q    <= gnt_ch;
    end
  end

  // A pending LSB snapshot only answers a low read of the same channel.
  always_comb begin
    rd_mux = ctr_q[i_rd_ch][31:0];
    if (i_rd_hi) begin
      rd_mux = ctr_q[i_rd_ch][63:32];
    end else if (sample_vld_q && (i_rd_ch == sample_ch_q)) begin
      rd_mux = sample_lsb_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (clr) begin
      sample_lsb_q <= '0;
      sample_ch_q  <= '0;
      sample_vld_q <= 1'b0;
    end else if (i_rd_req) begin
      if (i_rd_hi) begin
        sample_lsb_q <= ctr_q[i_rd_ch][31:0];
        sample_ch_q  <= i_rd_ch;
        sample_vld_q <= 1'b1;
      end else if (sample_vld_q && (i_rd_ch == sample_ch_q)) begin
        sample_vld_q <= 1'b0;
      end
    end
  end

  // Clear still answers a read in its own cycle; only reset kills the read path.
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q <= i_rd_req;
      if (i_rd_req) rd_data_q <= rd_mux;
    end
  end

  assign o_rd_ack  = rd_ack_q;
  assign o_rd_data = rd_data_q;
  assign o_drop    = drop_q;
  assign o_busy    = |req;

endmodule

// File: tb/tb_counter_bank_arbiter.sv
// Directed bench for counter_bank_arbiter: each task drives one scenario and
// compares outputs against hand-computed values.
`timescale 1ns/1ps
module tb_counter_bank_arbiter;

  localparam int N_CH   = 4;
  localparam int PEND_W = 4;
  localparam int CH_W   = 2;

  logic            clk = 1'b0;
  logic            areset;
  logic [N_CH-1:0] ev;
  logic            clear;
  logic            rd_req;
  logic [CH_W-1:0] rd_ch;
  logic            rd_hi;
  logic            rd_ack;
  logic [31:0]     rd_data;
  logic [N_CH-1:0] drop;
  logic            busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  counter_bank_arbiter #(.N_CH(N_CH), .PEND_W(PEND_W), .CH_W(CH_W)) dut (
    .i_clk     (clk),
    .i_areset  (areset),
    .i_event   (ev),
    .i_clear   (clear),
    .i_rd_req  (rd_req),
    .i_rd_ch   (rd_ch),
    .i_rd_hi   (rd_hi),
    .o_rd_ack  (rd_ack),
    .o_rd_data (rd_data),
    .o_drop    (drop),
    .o_busy    (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1; ev = '0; clear = 1'b0; rd_req = 1'b0; rd_ch = '0; rd_hi = 1'b0;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic do_read(input logic [CH_W-1:0] ch, input logic hi,
                         output logic ack, output logic [31:0] data);
    rd_req = 1'b1; rd_ch = ch; rd_hi = hi;
    tick();
    rd_req = 1'b0;
    ack  = rd_ack;
    data = rd_data;
  endtask

  task automatic drain(input int budget, output bit ok);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (rd_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack: got %b expected 0", rd_ack); end
    vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 00000000", rd_data); end
    vectors++; if (drop !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_drop: got %b expected 0000", drop); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_event();
    logic ack; logic [31:0] data;
    do_reset();
    ev = 4'b0010;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_t0: got %b expected 0", busy); end
    tick();
    ev = '0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_t1: got %b expected 1", busy); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_t2: got %b expected 0", busy); end
    do_read(2'd1, 1'b1, ack, data);
    vectors++; if (ack !== 1'b1 || data !== 32'h0) begin miscompares++; $display("[TB] FAIL single_rd_hi: got ack=%b data=%h expected ack=1 data=00000000", ack, data); end
    do_read(2'd1, 1'b0, ack, data);
    vectors++; if (ack !== 1'b1 || data !== 32'h1) begin miscompares++; $display("[TB] FAIL single_rd_lo: got ack=%b data=%h expected ack=1 data=00000001", ack, data); end
    tick();
    vectors++; if (rd_ack !== 1'b0 || rd_data !== 32'h1) begin miscompares++; $display("[TB] FAIL single_rd_hold: got ack=%b data=%h expected ack=0 data=00000001", rd_ack, rd_data); end
  endtask

  task automatic test_round_robin();
    logic [CH_W-1:0] rr_ch  [4] = '{2'd0, 2'd1, 2'd3, 2'd3};
    logic [31:0]     rr_exp [4] = '{32'd1, 32'd1, 32'd0, 32'd1};
    logic ack; logic [31:0] data; bit ok;
    do_reset();
    ev = '1;
    for (int c = 0; c < 8; c++) begin
      if (c >= 3 && c <= 6) begin
        vectors++;
        if (rd_ack !== 1'b1 || rd_data !== rr_exp[c-3]) begin
          miscompares++;
          $display("[TB] FAIL rr_rotation_c%0d: got ack=%b data=%h expected ack=1 data=%h", c, rd_ack, rd_data, rr_exp[c-3]);
        end
      end
      if (c >= 2 && c <= 5) begin
        rd_req = 1'b1; rd_ch = rr_ch[c-2]; rd_hi = 1'b0;
      end else begin
        rd_req = 1'b0;
      end
      tick();
    end
    ev = '0; rd_req = 1'b0;
    drain(64, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL rr_drain: got busy=%b expected 0", busy); end
    vectors++; if (drop !== 4'b0000) begin miscompares++; $display("[TB] FAIL rr_drop: got %b expected 0000", drop); end
    for (int ch = 0; ch < N_CH; ch++) begin
      do_read(CH_W'(ch), 1'b0, ack, data);
      vectors++; if (data !== 32'd8) begin miscompares++; $display("[TB] FAIL rr_ctr%0d: got %h expected 00000008", ch, data); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] sat_exp [4] = '{32'd21, 32'd21, 32'd21, 32'd20};
    logic ack; logic [31:0] data; bit ok;
    do_reset();
    ev = '1;
    for (int c = 0; c < 24; c++) begin
      if (c == 20) begin
        vectors++; if (drop !== 4'b1000) begin miscompares++; $display("[TB] FAIL sat_drop_c20: got %b expected 1000", drop); end
      end
      tick();
    end
    ev = '0;
    vectors++; if (drop !== 4'b1111) begin miscompares++; $display("[TB] FAIL sat_drop_end: got %b expected 1111", drop); end
    drain(100, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL sat_drain: got busy=%b expected 0", busy); end
    for (int ch = 0; ch < N_CH; ch++) begin
      do_read(CH_W'(ch), 1'b0, ack, data);
      vectors++; if (data !== sat_exp[ch]) begin miscompares++; $display("[TB] FAIL sat_ctr%0d: got %h expected %h", ch, data, sat_exp[ch]); end
    end
    vectors++; if (drop !== 4'b1111) begin miscompares++; $display("[TB] FAIL sat_drop_sticky: got %b expected 1111", drop); end
  endtask

  task automatic test_snapshot();
    logic ack; logic [31:0] data;
    do_reset();
    dut.ctr_q[2] = 64'h0000_0000_FFFF_FFFF;
    do_read(2'd2, 1'b1, ack, data);
    vectors++; if (data !== 32'h0000_0000) begin miscompares++; $display("[TB] FAIL snap_hi: got %h expected 00000000", data); end
    ev = 4'b0100; tick();
    ev = 4'b0100; tick();
    ev = '0;      tick();
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL snap_busy: got %b expected 0", busy); end
    do_read(2'd2, 1'b0, ack, data);
    vectors++; if (data !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL snap_lo_sample: got %h expected ffffffff", data); end
    do_read(2'd2, 1'b0, ack, data);
    vectors++; if (data !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL snap_lo_live: got %h expected 00000001", data); end
    do_read(2'd2, 1'b1, ack, data);
    vectors++; if (data !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL snap_hi_after: got %h expected 00000001", data); end
    do_read(2'd2, 1'b0, ack, data);
    vectors++; if (data !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL snap_lo_after: got %h expected 00000001", data); end
  endtask

  task automatic test_wrap();
    logic ack; logic [31:0] data;
    do_reset();
    dut.ctr_q[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    ev = 4'b1000; tick();
    ev = '0;      tick();
    tick();
    do_read(2'd3, 1'b1, ack, data);
    vectors++; if (data !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_hi: got %h expected 00000000", data); end
    do_read(2'd3, 1'b0, ack, data);
    vectors++; if (data !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_lo: got %h expected 00000000", data); end
    vectors++; if (drop !== 4'b0000) begin miscompares++; $display("[TB] FAIL wrap_drop: got %b expected 0000", drop); end
  endtask

  task automatic test_clear();
    logic ack; logic [31:0] data;
    do_reset();
    ev = '1;
    tick(); tick(); tick();
    clear = 1'b1; rd_req = 1'b1; rd_ch = 2'd0; rd_hi = 1'b0;
    tick();
    clear = 1'b0; rd_req = 1'b0; ev = '0;
    vectors++; if (rd_ack !== 1'b1 || rd_data !== 32'h1) begin miscompares++; $display("[TB] FAIL clr_read: got ack=%b data=%h expected ack=1 data=00000001", rd_ack, rd_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_busy: got %b expected 0", busy); end
    vectors++; if (drop !== 4'b0000) begin miscompares++; $display("[TB] FAIL clr_drop: got %b expected 0000", drop); end
    for (int ch = 0; ch < N_CH; ch++) begin
      do_read(CH_W'(ch), 1'b1, ack, data);
      vectors++; if (data !== 32'h0) begin miscompares++; $display("[TB] FAIL clr_hi%0d: got %h expected 00000000", ch, data); end
      do_read(CH_W'(ch), 1'b0, ack, data);
      vectors++; if (data !== 32'h0) begin miscompares++; $display("[TB] FAIL clr_lo%0d: got %h expected 00000000", ch, data); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic ack; logic [31:0] data;
    do_reset();
    ev = '1;
    for (int c = 0; c < 20; c++) begin
      if (c == 11) begin
        vectors++; if (rd_ack !== 1'b1 || rd_data !== 32'd3) begin miscompares++; $display("[TB] FAIL rst_mid_read: got ack=%b data=%h expected ack=1 data=00000003", rd_ack, rd_data); end
      end
      rd_req = (c == 10); rd_ch = 2'd0; rd_hi = 1'b0;
      tick();
    end
    vectors++; if (drop !== 4'b1000) begin miscompares++; $display("[TB] FAIL rst_mid_drop_pre: got %b expected 1000", drop); end
    areset = 1'b1; rd_req = 1'b1; rd_ch = 2'd1;
    tick();
    areset = 1'b0; rd_req = 1'b0; ev = '0;
    vectors++; if (rd_ack !== 1'b0 || rd_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mid_rd: got ack=%b data=%h expected ack=0 data=00000000", rd_ack, rd_data); end
    vectors++; if (drop !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_mid_drop: got %b expected 0000", drop); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
    for (int ch = 0; ch < N_CH; ch++) begin
      do_read(CH_W'(ch), 1'b0, ack, data);
      vectors++; if (data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mid_ctr%0d: got %h expected 00000000", ch, data); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_event();
    test_round_robin();
    test_saturation();
    test_snapshot();
    test_wrap();
    test_clear();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
